composer_fsm: RTL and testbench

Top-level sequencer for the composer. It decodes PS/2 scan-code bytes into user commands, walks the menu, mode-select, compose and end screens, and raises exactly one datapath enable at a time. It waits on the datapath's done handshakes and owns the note-slot count, including the full and empty decisions. It sits between the PS/2 controller and the datapath: the PS/2 bytes come in, and the datapath enables go out.

---
 rtl/composer_pkg.sv | 53 +++++
 rtl/ps2_cmd_decode.sv | 55 +++++
 rtl/composer_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_composer_fsm.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/composer_pkg.sv
// Shared types and scan-code constants for the composer sequencer.
// Included by the key decoder and the top-level FSM.
package composer_pkg;

  typedef enum logic [3:0] {
    ST_MENU,
    ST_LIST,
    ST_SONGS,
    ST_DRAW,
    ST_EDIT,
    ST_INSERT,
    ST_DELETE,
    ST_PLAY,
    ST_END
  } state_t;

  typedef enum logic [2:0] {
    NOTE_C, NOTE_D, NOTE_E, NOTE_F, NOTE_G, NOTE_A, NOTE_B
  } note_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_ENTER,
    CMD_ESC,
    CMD_PLAY,
    CMD_DELETE,
    CMD_COMPOSE,
    CMD_SONGS,
    CMD_NOTE
  } cmd_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ONE   = 8'h16;
  localparam logic [7:0] SC_TWO   = 8'h1E;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_J     = 8'h3B;

  // States that wait on a datapath done handshake under the timeout watchdog.
  function automatic logic is_timed(state_t s);
    return (s == ST_DRAW) || (s == ST_INSERT) || (s == ST_PLAY) || (s == ST_END);
  endfunction

endpackage

// File: rtl/ps2_cmd_decode.sv
// Turns PS/2 set-2 bytes into one-cycle user commands.
// Break codes (F0 xx) are swallowed; the E0 prefix is ignored entirely.
module ps2_cmd_decode
  import composer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] i_key_data,
  input  logic       i_key_valid,
  output logic       o_cmd_valid,
  output cmd_t       o_cmd,
  output note_t      o_note
);

  logic r_break;
  logic w_is_prefix;

  assign w_is_prefix = (i_key_data == SC_BREAK) || (i_key_data == SC_EXT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_break <= 1'b0;
    end else if (i_key_valid) begin
      if (i_key_data == SC_BREAK) begin
        r_break <= 1'b1;
      end else if (i_key_data != SC_EXT) begin
        r_break <= 1'b0;
      end
    end
  end

  // Combinational so a key in cycle t can move the FSM at the next edge.
  always_comb begin
    o_cmd_valid = i_key_valid && !w_is_prefix && !r_break;
    o_cmd       = CMD_NONE;
    o_note      = NOTE_C;
    case (i_key_data)
      SC_ENTER: o_cmd = CMD_ENTER;
      SC_ESC:   o_cmd = CMD_ESC;
      SC_SPACE: o_cmd = CMD_PLAY;
      SC_BKSP:  o_cmd = CMD_DELETE;
      SC_ONE:   o_cmd = CMD_COMPOSE;
      SC_TWO:   o_cmd = CMD_SONGS;
      SC_A:     begin o_cmd = CMD_NOTE; o_note = NOTE_C; end
      SC_S:     begin o_cmd = CMD_NOTE; o_note = NOTE_D; end
      SC_D:     begin o_cmd = CMD_NOTE; o_note = NOTE_E; end
      SC_F:     begin o_cmd = CMD_NOTE; o_note = NOTE_F; end
      SC_G:     begin o_cmd = CMD_NOTE; o_note = NOTE_G; end
      SC_H:     begin o_cmd = CMD_NOTE; o_note = NOTE_A; end
      SC_J:     begin o_cmd = CMD_NOTE; o_note = NOTE_B; end
      default:  o_cmd = CMD_NONE;
    endcase
  end

endmodule

// File: rtl/composer_fsm.sv
// Top-level composer sequencer: screen FSM, note-slot counter and done-handshake
// watchdog. Every output is a flop; enables are decoded from the next state.
module composer_fsm
  import composer_pkg::*;
#(
  parameter int MAX_NOTES = 16,
  parameter int CW        = 5,
  parameter int TIMEOUT   = 500_000_000,
  parameter int TW        = 29
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    key_data,
  input  logic          key_valid,
  input  logic          score_drawn,
  input  logic          insert_delay_done,
  input  logic          play_done,
  input  logic          end_done,
  output logic          menu_enable,
  output logic          list_enable,
  output logic          song_list_enable,
  output logic          draw_score,
  output logic          note_enable,
  output logic          insert_enable,
  output logic          delete_enable,
  output logic          play_enable,
  output logic          end_vga_display,
  output logic [2:0]    note_code,
  output logic [CW-1:0] note_count,
  output logic          is_full,
  output logic          timeout_err
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_NOTES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic          w_cmd_valid;
  cmd_t          w_cmd;
  note_t         w_note;
  logic [TW-1:0] r_timer;
  logic          w_expired;
  logic          w_abort;
  logic [CW-1:0] r_note_count;
  logic [CW-1:0] w_count_next;
  logic          r_is_full;
  note_t         r_note_code;
  logic          r_timeout_err;
  logic [8:0]    w_enables;
  logic [8:0]    r_enables;

  ps2_cmd_decode u_decode (
    .clock       (clock),
    .reset       (reset),
    .i_key_data  (key_data),
    .i_key_valid (key_valid),
    .o_cmd_valid (w_cmd_valid),
    .o_cmd       (w_cmd),
    .o_note      (w_note)
  );

  assign w_expired = (r_timer == TIMER_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_MENU;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Done inputs are tested before the watchdog so a same-cycle done wins.
  always_comb begin
    w_state_next = r_state;
    w_abort      = 1'b0;
    case (r_state)
      ST_MENU: begin
        if (w_cmd_valid && w_cmd == CMD_ENTER) w_state_next = ST_LIST;
      end
      ST_LIST: begin
        if (w_cmd_valid) begin
          case (w_cmd)
            CMD_COMPOSE: w_state_next = ST_DRAW;
            CMD_SONGS:   w_state_next = ST_SONGS;
            CMD_ESC:     w_state_next = ST_MENU;
            default:     w_state_next = ST_LIST;
          endcase
        end
      end
      ST_SONGS: begin
        if (w_cmd_valid && w_cmd == CMD_ESC) w_state_next = ST_LIST;
      end
      ST_DRAW: begin
        if (score_drawn) begin
          w_state_next = ST_EDIT;
        end else if (w_expired) begin
          w_state_next = ST_EDIT;
          w_abort      = 1'b1;
        end
      end
      ST_EDIT: begin
        if (w_cmd_valid) begin
          case (w_cmd)
            CMD_NOTE:   if (!r_is_full) w_state_next = ST_INSERT;
            CMD_DELETE: if (r_note_count != '0) w_state_next = ST_DELETE;
            CMD_PLAY:   if (r_note_count != '0) w_state_next = ST_PLAY;
            CMD_ESC:    w_state_next = ST_END;
            default:    w_state_next = ST_EDIT;
          endcase
        end
      end
      ST_INSERT: begin
        if (insert_delay_done) begin
          w_state_next = ST_EDIT;
        end else if (w_expired) begin
          w_state_next = ST_EDIT;
          w_abort      = 1'b1;
        end
      end
      ST_DELETE: w_state_next = ST_EDIT;
      ST_PLAY: begin
        if (play_done) begin
          w_state_next = ST_EDIT;
        end else if (w_expired) begin
          w_state_next = ST_EDIT;
          w_abort      = 1'b1;
        end
      end
      ST_END: begin
        if (end_done) begin
          w_state_next = ST_MENU;
        end else if (w_expired) begin
          w_state_next = ST_MENU;
          w_abort      = 1'b1;
        end
      end
      default: w_state_next = ST_MENU;
    endcase
  end

  // Bit order: menu, list, songs, draw, note, insert, delete, play, end.
  always_comb begin
    w_enables = '0;
    case (w_state_next)
      ST_MENU:   w_enables = 9'b1_0000_0000;
      ST_LIST:   w_enables = 9'b0_1000_0000;
      ST_SONGS:  w_enables = 9'b0_0100_0000;
      ST_DRAW:   w_enables = 9'b0_0010_0000;
      ST_EDIT:   w_enables = 9'b0_0001_0000;
      ST_INSERT: w_enables = 9'b0_0000_1000;
      ST_DELETE: w_enables = 9'b0_0000_0100;
      ST_PLAY:   w_enables = 9'b0_0000_0010;
      ST_END:    w_enables = 9'b0_0000_0001;
      default:   w_enables = '0;
    endcase
  end

  always_comb begin
    w_count_next = r_note_count;
    if (w_state_next == ST_DRAW && r_state != ST_DRAW) begin
      w_count_next = '0;
    end else if (r_state == ST_INSERT && insert_delay_done && r_note_count != FULL_COUNT) begin
      w_count_next = r_note_count + CW'(1);
    end else if (r_state == ST_DELETE && r_note_count != '0) begin
      w_count_next = r_note_count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_enables     <= 9'b1_0000_0000;
      r_timer       <= '0;
      r_note_count  <= '0;
      r_is_full     <= 1'b0;
      r_note_code   <= NOTE_C;
      r_timeout_err <= 1'b0;
    end else begin
      r_enables     <= w_enables;
      r_note_count  <= w_count_next;
      r_is_full     <= (w_count_next == FULL_COUNT);
      r_timeout_err <= w_abort;
      if (w_state_next != r_state) begin
        r_timer <= '0;
      end else if (is_timed(r_state)) begin
        r_timer <= r_timer + TW'(1);
      end
      if (r_state == ST_EDIT && w_cmd_valid && w_cmd == CMD_NOTE && !r_is_full) begin
        r_note_code <= w_note;
      end
    end
  end

  assign {menu_enable, list_enable, song_list_enable, draw_score, note_enable,
          insert_enable, delete_enable, play_enable, end_vga_display} = r_enables;
  assign note_code   = r_note_code;
  assign note_count  = r_note_count;
  assign is_full     = r_is_full;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_composer_fsm.sv
// Randomized and directed check of composer_fsm against a screen-level model
// that tracks the score as a queue of notes.
module tb_composer_fsm;

  localparam int MAX_NOTES = 16;
  localparam int CW        = 5;
  localparam int TIMEOUT   = 20;
  localparam int TW        = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    key_data = '0;
  logic          key_valid = 1'b0;
  logic          score_drawn = 1'b0;
  logic          insert_delay_done = 1'b0;
  logic          play_done = 1'b0;
  logic          end_done = 1'b0;
  logic          menu_enable, list_enable, song_list_enable, draw_score, note_enable;
  logic          insert_enable, delete_enable, play_enable, end_vga_display;
  logic [2:0]    note_code;
  logic [CW-1:0] note_count;
  logic          is_full;
  logic          timeout_err;

  always #5 clock = ~clock;

  composer_fsm #(
    .MAX_NOTES (MAX_NOTES),
    .CW        (CW),
    .TIMEOUT   (TIMEOUT),
    .TW        (TW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .key_data          (key_data),
    .key_valid         (key_valid),
    .score_drawn       (score_drawn),
    .insert_delay_done (insert_delay_done),
    .play_done         (play_done),
    .end_done          (end_done),
    .menu_enable       (menu_enable),
    .list_enable       (list_enable),
    .song_list_enable  (song_list_enable),
    .draw_score        (draw_score),
    .note_enable       (note_enable),
    .insert_enable     (insert_enable),
    .delete_enable     (delete_enable),
    .play_enable       (play_enable),
    .end_vga_display   (end_vga_display),
    .note_code         (note_code),
    .note_count        (note_count),
    .is_full           (is_full),
    .timeout_err       (timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  string m_screen = "MENU";
  bit    m_brk = 1'b0;
  int    m_wait = 0;
  int    m_score[$];
  int    m_pending = 0;
  int    m_code = 0;
  bit    m_terr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (screen %s)", tag, got, exp, m_screen);
    end
  endtask

  function automatic int note_index(input logic [7:0] kd);
    case (kd)
      8'h1C: return 0;
      8'h1B: return 1;
      8'h23: return 2;
      8'h2B: return 3;
      8'h34: return 4;
      8'h33: return 5;
      8'h3B: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic bit waits_on_done(input string s);
    return (s == "DRAW") || (s == "INSERT") || (s == "PLAY") || (s == "END");
  endfunction

  // {menu, list, songs, draw, note, insert, delete, play, end}
  function automatic logic [8:0] exp_en(input string s);
    case (s)
      "MENU":   return 9'h100;
      "LIST":   return 9'h080;
      "SONGS":  return 9'h040;
      "DRAW":   return 9'h020;
      "EDIT":   return 9'h010;
      "INSERT": return 9'h008;
      "DELETE": return 9'h004;
      "PLAY":   return 9'h002;
      "END":    return 9'h001;
      default:  return 9'h000;
    endcase
  endfunction

  task automatic model_reset();
    m_screen = "MENU";
    m_brk = 1'b0;
    m_wait = 0;
    m_score.delete();
    m_pending = 0;
    m_code = 0;
    m_terr = 1'b0;
  endtask

  task automatic model_step(input bit kv, input logic [7:0] kd, input bit sd,
                            input bit idd, input bit pd, input bit ed);
    bit    cmd = 1'b0;
    bit    expired;
    string nxt;
    int    n;
    m_terr = 1'b0;
    if (kv) begin
      if (kd == 8'hF0) m_brk = 1'b1;
      else if (kd != 8'hE0) begin
        if (m_brk) m_brk = 1'b0;
        else cmd = 1'b1;
      end
    end
    expired = (m_wait == TIMEOUT - 1);
    nxt = m_screen;
    case (m_screen)
      "MENU":  if (cmd && kd == 8'h5A) nxt = "LIST";
      "LIST": if (cmd) begin
        if (kd == 8'h16) begin nxt = "DRAW"; m_score.delete(); end
        else if (kd == 8'h1E) nxt = "SONGS";
        else if (kd == 8'h76) nxt = "MENU";
      end
      "SONGS": if (cmd && kd == 8'h76) nxt = "LIST";
      "DRAW": begin
        if (sd) nxt = "EDIT";
        else if (expired) begin nxt = "EDIT"; m_terr = 1'b1; end
      end
      "EDIT": if (cmd) begin
        n = note_index(kd);
        if (n >= 0) begin
          if (m_score.size() < MAX_NOTES) begin
            m_pending = n; m_code = n; nxt = "INSERT";
          end
        end else if (kd == 8'h66 && m_score.size() > 0) nxt = "DELETE";
        else if (kd == 8'h29 && m_score.size() > 0) nxt = "PLAY";
        else if (kd == 8'h76) nxt = "END";
      end
      "INSERT": begin
        if (idd) begin m_score.push_back(m_pending); nxt = "EDIT"; end
        else if (expired) begin nxt = "EDIT"; m_terr = 1'b1; end
      end
      "DELETE": begin
        void'(m_score.pop_back());
        nxt = "EDIT";
      end
      "PLAY": begin
        if (pd) nxt = "EDIT";
        else if (expired) begin nxt = "EDIT"; m_terr = 1'b1; end
      end
      "END": begin
        if (ed) nxt = "MENU";
        else if (expired) begin nxt = "MENU"; m_terr = 1'b1; end
      end
      default: nxt = "MENU";
    endcase
    if (nxt != m_screen) m_wait = 0;
    else if (waits_on_done(nxt)) m_wait++;
    else m_wait = 0;
    m_screen = nxt;
  endtask

  task automatic check_all();
    chk("enables", {23'd0, menu_enable, list_enable, song_list_enable, draw_score, note_enable,
                    insert_enable, delete_enable, play_enable, end_vga_display},
        {23'd0, exp_en(m_screen)});
    chk("note_count", 32'(note_count), m_score.size());
    chk("is_full", 32'(is_full), (m_score.size() == MAX_NOTES) ? 1 : 0);
    chk("note_code", 32'(note_code), m_code);
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic cycle(input bit kv, input logic [7:0] kd, input bit sd, input bit idd,
                       input bit pd, input bit ed, input bit rst);
    @(negedge clock);
    reset = rst;
    key_valid = kv;
    key_data = kd;
    score_drawn = sd;
    insert_delay_done = idd;
    play_done = pd;
    end_done = ed;
    if (rst) model_reset();
    else model_step(kv, kd, sd, idd, pd, ed);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic press(input logic [7:0] kd);
    cycle(1'b1, kd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("key 0x%02h -> %s count=%0d", kd, m_screen, m_score.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic insert_note(input logic [7:0] kd);
    press(kd);
    idle(2);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] pool [16] = '{8'h5A, 8'h76, 8'h29, 8'h66, 8'h16, 8'h1E, 8'h1C, 8'h1B,
                            8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'hF0, 8'hE0, 8'h00};

  initial begin
    int ins;
    int terr;
    int dels;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("reset -> %s", m_screen);
    chk("reset_menu", 32'(menu_enable), 1);

    press(8'h5A);
    press(8'h16);
    idle(2);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("score_drawn -> %s", m_screen);
    chk("edit_entry", 32'(note_enable), 1);

    press(8'h1C);
    ins = int'(insert_enable);
    for (int i = 0; i < 7; i++) begin idle(1); ins += int'(insert_enable); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ins += int'(insert_enable);
    chk("insert_len", ins, 8);
    chk("insert_count", 32'(note_count), 1);
    press(8'hF0);
    press(8'h1C);
    chk("break_no_insert", 32'(insert_enable), 0);

    for (int i = 1; i < MAX_NOTES; i++) insert_note(pool[6 + (i % 7)]);
    chk("full_flag", 32'(is_full), 1);
    press(8'h23);
    chk("full_stays_edit", 32'(note_enable), 1);
    press(8'h66);
    dels = int'(delete_enable);
    idle(1);
    dels += int'(delete_enable);
    chk("delete_pulse", dels, 1);
    chk("after_delete_count", 32'(note_count), 15);
    chk("after_delete_full", 32'(is_full), 0);

    press(8'h76);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    press(8'h5A);
    press(8'h16);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press(8'h29);
    chk("empty_play_ignored", 32'(note_enable), 1);
    for (int i = 0; i < 3; i++) insert_note(8'h3B);
    press(8'h29);
    chk("play_entered", 32'(play_enable), 1);
    idle(5);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("play_count_kept", 32'(note_count), 3);

    press(8'h34);
    ins = int'(insert_enable);
    terr = 0;
    for (int i = 0; i < 25; i++) begin
      idle(1);
      ins += int'(insert_enable);
      terr += int'(timeout_err);
    end
    $display("insert timeout -> %s count=%0d", m_screen, m_score.size());
    chk("timeout_insert_len", ins, 20);
    chk("timeout_pulses", terr, 1);
    chk("timeout_count", 32'(note_count), 3);

    press(8'h29);
    idle(3);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("reset mid-play -> %s", m_screen);
    chk("rst_menu", 32'(menu_enable), 1);
    chk("rst_play", 32'(play_enable), 0);
    chk("rst_count", 32'(note_count), 0);

    for (int i = 0; i < 4000; i++) begin
      bit         kv;
      logic [7:0] kd;
      int         pick;
      if ($urandom_range(0, 999) < 2) begin
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("random reset -> %s", m_screen);
      end else begin
        kv = ($urandom_range(0, 3) == 0);
        pick = int'($urandom_range(0, 15));
        kd = (pick == 15) ? 8'($urandom) : pool[pick];
        cycle(kv, kd, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 1'b0);
        if (kv) $display("key 0x%02h -> %s count=%0d", kd, m_screen, m_score.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
